carregador_programa: RTL and testbench
======================================

# carregador_programa

Program-memory loader for the stack processor. Receives a framed byte stream (sync, start address, word count, 16-bit words, checksum) and writes each word into program memory through the same write port the control unit normally holds read-only. It also holds the program counter in halt while a load is in progress. It sits between the external byte source (serial/host link) and the program memory write port, as the writer counterpart to the instruction-reading side.

## Interface
- ADDR_WIDTH, 16, program memory address width.
- SYNC_BYTE, 8'hA5, frame start marker.

- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_byte  input  8  incoming byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_WIDTH  program memory write address.
- mem_data  output  16  program memory write data.
- mem_we  output  1  program memory write enable, one-cycle pulse per word.
- halt_cpu  output  1  hold program counter / instruction issue.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse on successful frame end.
- error  output  1  sticky: last frame failed checksum.

## Operation
- Byte accepted on a rising edge when in_valid && in_ready. Words are MSB byte first.
- Frame: SYNC_BYTE, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT × (DATA_H, DATA_L), then CHK.
- CHK is the XOR of every byte after SYNC_BYTE up to, but not including, CHK.
- FSM states: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, WRITE, CHECK, DONE.
  - IDLE: non-sync bytes are consumed and discarded. A sync byte moves to ADDR_H, clears error, clears the XOR accumulator, and sets halt_cpu and busy.
  - ADDR_H → ADDR_L → CNT_H → CNT_L on each accepted byte. The address is truncated or zero-extended to ADDR_WIDTH.
  - After CNT_L: go to CHECK if the count is 0, otherwise DATA_H.
  - DATA_H → DATA_L → WRITE.
  - WRITE lasts one cycle, with in_ready=0 and mem_we=1. On exit, mem_addr increments modulo 2^ADDR_WIDTH and the count decrements. Go to CHECK when the count reaches 0, otherwise DATA_H.
  - CHECK: on an accepted byte, a mismatch sets error; either way, go to DONE.
  - DONE lasts one cycle, with in_ready=0. done=1 only if CHK matched. Then go to IDLE, and halt_cpu and busy drop.
- Words written before a checksum failure remain in memory. The loader does not roll back.
- A sync byte seen mid-frame is treated as ordinary data; there is no resynchronisation.
- Count is 16 bits. A full-range count wraps the address across the whole memory.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. mem_addr=0, mem_data=0, mem_we=0, halt_cpu=0, busy=0, done=0, error=0.
- All outputs are registered or decoded from the registered state. No combinational path runs from in_valid to any output.
- mem_we asserts in the cycle after DATA_L is accepted, with mem_addr and mem_data stable for that whole cycle.
- Minimum frame duration is one cycle per byte, plus one WRITE cycle per word, plus one DONE cycle.
- halt_cpu rises in the cycle after the sync byte is accepted. It falls in the cycle after DONE.
- A reset mid-frame returns to IDLE next cycle with all outputs at reset values. No partial word is written.
- in_valid gaps are allowed in any state. The FSM waits.

## Configuration
- CARREGADOR_CHECKSUM_EN
  - Defined: the CHK byte is expected and verified as above.
  - Undefined: there is no CHECK state and no CHK byte. After the final WRITE, or after CNT_L with count 0, the FSM goes directly to DONE. done always pulses, and error stays 0.

## Test plan
- Normal load: A5 00 10 00 02 12 34 AB CD 52 → writes 0x1234@0x0010 then 0xABCD@0x0011. done pulses once, error=0, halt_cpu high from after A5 through DONE.
- Bad checksum: same frame with last byte 53 → both writes still occur, done=0, error=1 (sticky). error clears on the next A5.
- Empty frame: A5 01 00 00 00 01 → no mem_we, done pulses.
- Address wrap: A5 FF FF 00 02 00 01 00 02 01 → writes 0x0001@0xFFFF then 0x0002@0x0000, done pulses.
- Reset mid-frame: rst after A5 00 10 → next cycle busy=0, halt_cpu=0, no mem_we. The full normal-load frame then succeeds.
- Garbage and gaps: 00 FF before A5, then the normal-load frame with random in_valid gaps → garbage ignored, identical writes and done.
- Macro undefined: A5 00 10 00 01 BE EF → writes 0xBEEF@0x0010, done pulses with no checksum byte.

Source files
------------

// File: rtl/carregador_programa_if.sv
// Byte-stream input and program-memory write port of the program loader.
// master: the loader side; slave: byte source plus memory/control-unit side.
interface carregador_programa_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data;
  logic                  mem_we;
  logic                  halt_cpu;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  in_byte, in_valid,
    output in_ready, mem_addr, mem_data, mem_we, halt_cpu, busy, done, error
  );

  modport slave (
    output in_byte, in_valid,
    input  in_ready, mem_addr, mem_data, mem_we, halt_cpu, busy, done, error
  );
endinterface

// File: rtl/carregador_programa.sv
// Program-memory loader: parses SYNC/ADDR/CNT/words[/CHK] frames and writes words to memory.
// Define CARREGADOR_CHECKSUM_EN to expect and verify the trailing XOR checksum byte.
module carregador_programa #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input logic                   clk,
  input logic                   rst,
  carregador_programa_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StAddrH, StAddrL, StCntH, StCntL, StDataH, StDataL, StWrite,
`ifdef CARREGADOR_CHECKSUM_EN
    StCheck,
`endif
    StDone
  } state_e;

`ifdef CARREGADOR_CHECKSUM_EN
  localparam state_e StTail = StCheck;
`else
  localparam state_e StTail = StDone;
`endif

  state_e                state_q, state_d;
  logic [7:0]            addr_hi_q, addr_hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           data_q, data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;
  logic                  match;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  always_comb begin
    accept    = bus.in_valid && in_ready_q;
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    error_d   = error_q;
    match     = 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
    chk_d     = chk_q;
    // Everything between SYNC and CHK feeds the running checksum.
    if (accept && state_q != StIdle && state_q != StCheck) begin
      chk_d = chk_q ^ bus.in_byte;
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (accept && bus.in_byte == SYNC_BYTE) begin
          state_d = StAddrH;
          error_d = 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
          chk_d   = 8'h00;
`endif
        end
      end
      StAddrH: if (accept) begin
        addr_hi_d = bus.in_byte;
        state_d   = StAddrL;
      end
      StAddrL: if (accept) begin
        addr_d  = ADDR_WIDTH'({addr_hi_q, bus.in_byte});
        state_d = StCntH;
      end
      StCntH: if (accept) begin
        cnt_d[15:8] = bus.in_byte;
        state_d     = StCntL;
      end
      StCntL: if (accept) begin
        cnt_d[7:0] = bus.in_byte;
        state_d    = ({cnt_q[15:8], bus.in_byte} == 16'd0) ? StTail : StDataH;
      end
      StDataH: if (accept) begin
        data_d[15:8] = bus.in_byte;
        state_d      = StDataL;
      end
      StDataL: if (accept) begin
        data_d[7:0] = bus.in_byte;
        state_d     = StWrite;
      end
      StWrite: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? StTail : StDataH;
      end
`ifdef CARREGADOR_CHECKSUM_EN
      StCheck: if (accept) begin
        match   = (bus.in_byte == chk_q);
        error_d = !match;
        state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so nothing reaches them combinationally.
    in_ready_d = !(state_d == StWrite || state_d == StDone);
    mem_we_d   = (state_d == StWrite);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone) && match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_hi_q  <= 8'h00;
      addr_q     <= '0;
      cnt_q      <= 16'd0;
      data_q     <= 16'd0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef CARREGADOR_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.halt_cpu = busy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Directed bench for carregador_programa; frames carry a CHK byte that is dropped
// when CARREGADOR_CHECKSUM_EN is undefined.
module tb_carregador_programa;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  carregador_programa_if #(.ADDR_WIDTH(16)) bus ();

  carregador_programa #(
    .ADDR_WIDTH(16),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture writes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
    end
    if (!rst && bus.done) begin
      done_cnt++;
      check_eq("halt_at_done", {31'd0, bus.halt_cpu}, 32'd1);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input bytes_t f, input int maxgap);
    int n;
`ifdef CARREGADOR_CHECKSUM_EN
    n = f.size();
`else
    n = f.size() - 1;
`endif
    for (int i = 0; i < n; i++) send_byte(f[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 40) begin @(posedge clk); #1; t++; end
    check_eq("idle_timeout", {31'd0, bus.busy}, 32'd0);
    check_eq("halt_dropped", {31'd0, bus.halt_cpu}, 32'd0);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [15:0] a0,
                              input logic [15:0] d0, input logic [15:0] a1, input logic [15:0] d1);
    check_eq({tag, "_nwr"}, wr_addr.size(), n);
    if (n > 0 && wr_addr.size() > 0) begin
      check_eq({tag, "_a0"}, {16'd0, wr_addr[0]}, {16'd0, a0});
      check_eq({tag, "_d0"}, {16'd0, wr_data[0]}, {16'd0, d0});
    end
    if (n > 1 && wr_addr.size() > 1) begin
      check_eq({tag, "_a1"}, {16'd0, wr_addr[1]}, {16'd0, a1});
      check_eq({tag, "_d1"}, {16'd0, wr_data[1]}, {16'd0, d1});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bytes_t normal, bad, empty, wrap, part, beef;
    normal = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    bad    = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h53};
    empty  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    wrap   = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
    part   = '{8'hA5, 8'h00, 8'h10};
    beef   = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h40};
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check_eq("rst_mem_data", {16'd0, bus.mem_data}, 32'd0);
    check_eq("rst_mem_we",   {31'd0, bus.mem_we},   32'd0);
    check_eq("rst_halt",     {31'd0, bus.halt_cpu}, 32'd0);
    check_eq("rst_busy",     {31'd0, bus.busy},     32'd0);
    check_eq("rst_done",     {31'd0, bus.done},     32'd0);
    check_eq("rst_error",    {31'd0, bus.error},    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Normal load, checking halt right after the sync byte
    clear_log();
    send_byte(8'hA5, 0);
    check_eq("sync_halt", {31'd0, bus.halt_cpu}, 32'd1);
    check_eq("sync_busy", {31'd0, bus.busy},     32'd1);
    normal.delete(0);
    send_frame(normal, 0);
    wait_idle();
    check_writes("normal", 2, 16'h0010, 16'h1234, 16'h0011, 16'hABCD);
    check_eq("normal_done",  done_cnt, 1);
    check_eq("normal_error", {31'd0, bus.error}, 32'd0);
    check_eq("normal_ready", {31'd0, bus.in_ready}, 32'd1);

`ifdef CARREGADOR_CHECKSUM_EN
    // Bad checksum: writes kept, no done, sticky error
    clear_log();
    send_frame(bad, 0);
    wait_idle();
    check_writes("bad", 2, 16'h0010, 16'h1234, 16'h0011, 16'hABCD);
    check_eq("bad_done",  done_cnt, 0);
    check_eq("bad_error", {31'd0, bus.error}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bad_sticky", {31'd0, bus.error}, 32'd1);
`endif

    // Empty frame; the sync byte clears a previous error
    clear_log();
    send_byte(8'hA5, 0);
    check_eq("sync_clears_error", {31'd0, bus.error}, 32'd0);
    empty.delete(0);
    send_frame(empty, 0);
    wait_idle();
    check_writes("empty", 0, 16'h0, 16'h0, 16'h0, 16'h0);
    check_eq("empty_done", done_cnt, 1);

    // Address wrap
    clear_log();
    send_frame(wrap, 0);
    wait_idle();
    check_writes("wrap", 2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0002);
    check_eq("wrap_done", done_cnt, 1);

    // Reset mid-frame, then a full frame
    clear_log();
    for (int i = 0; i < part.size(); i++) send_byte(part[i], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_busy",   {31'd0, bus.busy},     32'd0);
    check_eq("midrst_halt",   {31'd0, bus.halt_cpu}, 32'd0);
    check_eq("midrst_mem_we", {31'd0, bus.mem_we},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_nwr", wr_addr.size(), 0);
    normal = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
    send_frame(normal, 0);
    wait_idle();
    check_writes("after_rst", 2, 16'h0010, 16'h1234, 16'h0011, 16'hABCD);
    check_eq("after_rst_done", done_cnt, 1);

    // Garbage before sync, then gapped stream
    clear_log();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 2);
    check_eq("garbage_busy", {31'd0, bus.busy}, 32'd0);
    send_frame(normal, 3);
    wait_idle();
    check_writes("gaps", 2, 16'h0010, 16'h1234, 16'h0011, 16'hABCD);
    check_eq("gaps_done",  done_cnt, 1);
    check_eq("gaps_error", {31'd0, bus.error}, 32'd0);

    // Single word
    clear_log();
    send_frame(beef, 0);
    wait_idle();
    check_writes("beef", 1, 16'h0010, 16'hBEEF, 16'h0, 16'h0);
    check_eq("beef_done",  done_cnt, 1);
    check_eq("beef_error", {31'd0, bus.error}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
